// File: rtl/toy_bpu_bht_update_pkg.sv
// Shared branch-history-table types, defaults and helpers for the BHT
// trainer and the fetch predictor.
package toy_bpu_bht_update_pkg;

  localparam int unsigned BHT_DEPTH = 256;

  typedef logic [1:0] bht_cnt_t;

  localparam bht_cnt_t CNT_INIT = 2'b01;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_CLR = 1'b1
  } bht_state_e;

  // Folded index: low index field XOR the next field up. Callers truncate
  // the result to their own index width.
  function automatic logic [31:0] bht_idx(input logic [63:0] pc, input int unsigned idx_w);
    return 32'(pc >> 2) ^ 32'(pc >> (idx_w + 2));
  endfunction

  function automatic bht_cnt_t bht_sat_update(input bht_cnt_t cnt, input logic taken);
    bht_cnt_t nxt;
    nxt = cnt;
    if (taken && cnt != 2'd3) nxt = cnt + 2'd1;
    if (!taken && cnt != 2'd0) nxt = cnt - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/toy_bpu_bht_update_array.sv
// Flop-based counter array: one training write, one clear write (wins on
// collision), two read ports that see the same-cycle training write.
module toy_bpu_bht_array
  import toy_bpu_bht_update_pkg::*;
#(
  parameter int unsigned DEPTH    = 256,
  parameter int unsigned IDX_W    = 8,
  parameter bht_cnt_t    INIT_CNT = 2'b01
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  bht_cnt_t         wr_cnt,
  input  logic             clr_en,
  input  logic [IDX_W-1:0] clr_idx,
  input  logic [IDX_W-1:0] rd0_idx,
  output bht_cnt_t         rd0_cnt,
  input  logic [IDX_W-1:0] rd1_idx,
  output bht_cnt_t         rd1_cnt
);

  bht_cnt_t mem_q [DEPTH];
  bht_cnt_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en)  mem_d[wr_idx]  = wr_cnt;
    if (clr_en) mem_d[clr_idx] = INIT_CNT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= INIT_CNT;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd0_cnt = (wr_en && wr_idx == rd0_idx) ? wr_cnt : mem_q[rd0_idx];
  assign rd1_cnt = (wr_en && wr_idx == rd1_idx) ? wr_cnt : mem_q[rd1_idx];

endmodule

// File: rtl/toy_bpu_bht_update.sv
// BHT trainer: 2-stage read-modify-write of 2-bit counters from the commit
// stream, 1-cycle fetch lookup, committed-cancel redirect and a table clear FSM.
module toy_bpu_bht_update #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BHT_DEPTH  = toy_bpu_bht_update_pkg::BHT_DEPTH,
  parameter logic [1:0]  CNT_INIT   = toy_bpu_bht_update_pkg::CNT_INIT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  fe_commit_vld,
  input  logic [ADDR_WIDTH-1:0] fe_commit_pc,
  input  logic                  fe_commit_taken,
  input  logic [ADDR_WIDTH-1:0] fe_commit_tgt_pc,
  input  logic                  fe_cancel_vld,
  input  logic                  fe_cancel_pend,
  input  logic                  lookup_vld,
  input  logic [ADDR_WIDTH-1:0] lookup_pc,
  output logic                  lookup_rsp_vld,
  output logic                  lookup_taken,
  output logic                  redirect_vld,
  output logic [ADDR_WIDTH-1:0] redirect_pc,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  import toy_bpu_bht_update_pkg::*;

  localparam int unsigned      IDX_W    = $clog2(BHT_DEPTH);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(BHT_DEPTH - 1);
  localparam logic [IDX_W-1:0] PTR_PEN  = IDX_W'(BHT_DEPTH - 2);

  bht_state_e       state_q;
  logic [IDX_W-1:0] clr_ptr_q;
  logic             clr_busy_q, clr_done_q;

  logic             s1_vld_q, s1_vld_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic             s1_taken_q, s1_taken_d;
  bht_cnt_t         s1_cnt_q, s1_cnt_d;

  logic                  lookup_rsp_vld_q, lookup_rsp_vld_d;
  logic                  lookup_taken_q, lookup_taken_d;
  logic                  redirect_vld_q, redirect_vld_d;
  logic [ADDR_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  logic [IDX_W-1:0] commit_idx, lookup_idx;
  bht_cnt_t         commit_cnt, lookup_cnt, s1_new_cnt;
  logic             in_clr, redirect_fire;

  assign in_clr     = (state_q == ST_CLR);
  assign commit_idx = IDX_W'(bht_idx(64'(fe_commit_pc), IDX_W));
  assign lookup_idx = IDX_W'(bht_idx(64'(lookup_pc), IDX_W));
  assign s1_new_cnt = bht_sat_update(s1_cnt_q, s1_taken_q);

  // Both read ports bypass the S1 write, which gives S0 forwarding for
  // back-to-back commits and makes in-flight training visible to lookups.
  toy_bpu_bht_array #(
    .DEPTH    (BHT_DEPTH),
    .IDX_W    (IDX_W),
    .INIT_CNT (CNT_INIT)
  ) u_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (s1_vld_q),
    .wr_idx  (s1_idx_q),
    .wr_cnt  (s1_new_cnt),
    .clr_en  (in_clr),
    .clr_idx (clr_ptr_q),
    .rd0_idx (commit_idx),
    .rd0_cnt (commit_cnt),
    .rd1_idx (lookup_idx),
    .rd1_cnt (lookup_cnt)
  );

  always_comb begin
    s1_vld_d   = fe_commit_vld && !in_clr;
    s1_idx_d   = commit_idx;
    s1_taken_d = fe_commit_taken;
    s1_cnt_d   = commit_cnt;

    lookup_rsp_vld_d = lookup_vld;
    lookup_taken_d   = !in_clr && (lookup_cnt >= 2'd2);

    redirect_fire  = fe_commit_vld && fe_cancel_vld && !fe_cancel_pend;
    redirect_vld_d = redirect_fire;
    redirect_pc_d  = redirect_fire ? fe_commit_tgt_pc : redirect_pc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q         <= 1'b0;
      s1_idx_q         <= '0;
      s1_taken_q       <= 1'b0;
      s1_cnt_q         <= '0;
      lookup_rsp_vld_q <= 1'b0;
      lookup_taken_q   <= 1'b0;
      redirect_vld_q   <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      s1_vld_q         <= s1_vld_d;
      s1_idx_q         <= s1_idx_d;
      s1_taken_q       <= s1_taken_d;
      s1_cnt_q         <= s1_cnt_d;
      lookup_rsp_vld_q <= lookup_rsp_vld_d;
      lookup_taken_q   <= lookup_taken_d;
      redirect_vld_q   <= redirect_vld_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  // clr_done is raised one cycle early so it coincides with the last write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      clr_ptr_q  <= '0;
      clr_busy_q <= 1'b0;
      clr_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          clr_done_q <= 1'b0;
          if (clr_req) begin
            state_q    <= ST_CLR;
            clr_ptr_q  <= '0;
            clr_busy_q <= 1'b1;
          end
        end
        ST_CLR: begin
          clr_ptr_q  <= clr_ptr_q + IDX_W'(1);
          clr_done_q <= (clr_ptr_q == PTR_PEN);
          if (clr_ptr_q == PTR_LAST) begin
            state_q    <= ST_RUN;
            clr_busy_q <= 1'b0;
            clr_done_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_RUN;
          clr_busy_q <= 1'b0;
          clr_done_q <= 1'b0;
        end
      endcase
    end
  end

  assign lookup_rsp_vld = lookup_rsp_vld_q;
  assign lookup_taken   = lookup_taken_q;
  assign redirect_vld   = redirect_vld_q;
  assign redirect_pc    = redirect_pc_q;
  assign clr_busy       = clr_busy_q;
  assign clr_done       = clr_done_q;

endmodule

// File: tb/tb_toy_bpu_bht_update.sv
// Self-checking bench for toy_bpu_bht_update against a per-entry counter model.
module tb_toy_bpu_bht_update;

  localparam int AW    = 32;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          fe_commit_vld, fe_commit_taken, fe_cancel_vld, fe_cancel_pend;
  logic [AW-1:0] fe_commit_pc, fe_commit_tgt_pc;
  logic          lookup_vld;
  logic [AW-1:0] lookup_pc;
  logic          lookup_rsp_vld, lookup_taken, redirect_vld;
  logic [AW-1:0] redirect_pc;
  logic          clr_req, clr_busy, clr_done;

  always #5 clk = ~clk;

  toy_bpu_bht_update #(
    .ADDR_WIDTH (AW),
    .BHT_DEPTH  (DEPTH),
    .CNT_INIT   (2'b01)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .fe_commit_vld    (fe_commit_vld),
    .fe_commit_pc     (fe_commit_pc),
    .fe_commit_taken  (fe_commit_taken),
    .fe_commit_tgt_pc (fe_commit_tgt_pc),
    .fe_cancel_vld    (fe_cancel_vld),
    .fe_cancel_pend   (fe_cancel_pend),
    .lookup_vld       (lookup_vld),
    .lookup_pc        (lookup_pc),
    .lookup_rsp_vld   (lookup_rsp_vld),
    .lookup_taken     (lookup_taken),
    .redirect_vld     (redirect_vld),
    .redirect_pc      (redirect_pc),
    .clr_req          (clr_req),
    .clr_busy         (clr_busy),
    .clr_done         (clr_done)
  );

  // Reference model: plain integer counter per entry and a clear countdown.
  int            model [DEPTH];
  int            clr_left;
  logic [AW-1:0] last_rpc;
  logic          exp_rsp, exp_taken, exp_rvld, exp_busy, exp_done;
  logic [AW-1:0] exp_rpc;
  int            checks = 0;
  int            passes = 0;

  function automatic int idx_of(input logic [AW-1:0] pc);
    return int'(((pc >> 2) ^ (pc >> 10)) & (DEPTH - 1));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = 1;
    clr_left = 0;
    last_rpc = '0;
  endtask

  task automatic drive_idle();
    fe_commit_vld = 0; fe_commit_pc = '0; fe_commit_taken = 0; fe_commit_tgt_pc = '0;
    fe_cancel_vld = 0; fe_cancel_pend = 0; lookup_vld = 0; lookup_pc = '0; clr_req = 0;
  endtask

  // Drives one beat, advances the model to produce post-edge expectations,
  // then waits until just after the clock edge.
  task automatic cycle(input logic cvld, input logic [AW-1:0] cpc, input logic tk,
                       input logic cc, input logic cp, input logic [AW-1:0] tgt,
                       input logic lv, input logic [AW-1:0] lpc, input logic cr);
    bit busy_now;
    int k;
    fe_commit_vld = cvld; fe_commit_pc = cpc; fe_commit_taken = tk; fe_commit_tgt_pc = tgt;
    fe_cancel_vld = cc; fe_cancel_pend = cp; lookup_vld = lv; lookup_pc = lpc; clr_req = cr;
    busy_now  = (clr_left > 0);
    exp_rsp   = lv;
    exp_taken = !busy_now && (model[idx_of(lpc)] >= 2);
    exp_rvld  = cvld && cc && !cp;
    if (exp_rvld) last_rpc = tgt;
    exp_rpc = last_rpc;
    if (!busy_now && cvld) begin
      k = idx_of(cpc);
      model[k] = tk ? ((model[k] == 3) ? 3 : model[k] + 1) : ((model[k] == 0) ? 0 : model[k] - 1);
    end
    if (busy_now) begin
      clr_left--;
      if (clr_left == 0) for (int i = 0; i < DEPTH; i++) model[i] = 1;
    end else if (cr) begin
      clr_left = DEPTH;
    end
    exp_busy = (clr_left > 0);
    exp_done = (clr_left == 1);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_idle();
    model_reset();
    rst_n = 0;
    #3;
    checks++;
    if ({lookup_rsp_vld, lookup_taken, redirect_vld, clr_busy, clr_done} !== 5'b0 || redirect_pc !== '0)
      $display("FAIL reset_outputs: got rsp=%b tk=%b rv=%b busy=%b done=%b rpc=%h, want all 0",
               lookup_rsp_vld, lookup_taken, redirect_vld, clr_busy, clr_done, redirect_pc);
    else passes++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h1000, 0);
    checks++;
    if (lookup_rsp_vld !== 1'b1 || lookup_taken !== 1'b0)
      $display("FAIL reset_lookup: got rsp=%b taken=%b, want rsp=1 taken=0", lookup_rsp_vld, lookup_taken);
    else passes++;
    checks++;
    if ({redirect_vld, clr_busy, clr_done} !== 3'b0 || redirect_pc !== '0)
      $display("FAIL reset_idle_outputs: got rv=%b busy=%b done=%b rpc=%h, want 0",
               redirect_vld, clr_busy, clr_done, redirect_pc);
    else passes++;
  endtask

  task automatic test_saturate();
    logic tk_seq [9] = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    for (int i = 0; i < 3; i++) cycle(1, 32'h1000, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h1000, 0);
    checks++;
    if (lookup_taken !== exp_taken || exp_taken !== 1'b1)
      $display("FAIL sat_chain: got taken=%b, want %b (model cnt=%0d)", lookup_taken, exp_taken, model[4]);
    else passes++;
    // 4th taken then not-takens walk down through saturation at both ends.
    for (int i = 4; i < 9; i++) begin
      cycle(1, 32'h1000, tk_seq[i], 0, 0, 0, 1, 32'h1000, 0);
      checks++;
      if (lookup_taken !== exp_taken)
        $display("FAIL sat_walk_%0d: got taken=%b, want %b", i, lookup_taken, exp_taken);
      else passes++;
    end
    cycle(1, 32'h1000, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h1000, 0);
    checks++;
    if (lookup_taken !== exp_taken)
      $display("FAIL sat_floor: got taken=%b, want %b (model cnt=%0d)", lookup_taken, exp_taken, model[4]);
    else passes++;
  endtask

  task automatic test_alias();
    logic [AW-1:0] pa, pl;
    for (int i = 0; i < 16; i++) begin
      pa = (i % 2 == 0) ? 32'h1000 : 32'h1404;
      pl = (i % 2 == 0) ? 32'h1404 : 32'h1000;
      cycle(1, pa, 1'($urandom_range(0, 1)), 0, 0, 0, 1, pl, 0);
      checks++;
      if (lookup_rsp_vld !== exp_rsp || lookup_taken !== exp_taken)
        $display("FAIL alias_%0d: got rsp=%b taken=%b, want rsp=%b taken=%b",
                 i, lookup_rsp_vld, lookup_taken, exp_rsp, exp_taken);
      else passes++;
    end
  endtask

  task automatic test_redirect();
    cycle(1, 32'h1000, 0, 1, 0, 32'h2040, 0, 0, 0);
    checks++;
    if (redirect_vld !== 1'b1 || redirect_pc !== 32'h2040)
      $display("FAIL redirect_pulse: got vld=%b pc=%h, want 1 00002040", redirect_vld, redirect_pc);
    else passes++;
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (redirect_vld !== 1'b0 || redirect_pc !== 32'h2040)
      $display("FAIL redirect_hold: got vld=%b pc=%h, want 0 00002040", redirect_vld, redirect_pc);
    else passes++;
    cycle(1, 32'h1000, 0, 1, 1, 32'h3000, 0, 0, 0);
    checks++;
    if (redirect_vld !== 1'b0 || redirect_pc !== 32'h2040)
      $display("FAIL redirect_pend: got vld=%b pc=%h, want 0 00002040", redirect_vld, redirect_pc);
    else passes++;
    cycle(0, 32'h1000, 0, 1, 0, 32'h4000, 0, 0, 0);
    checks++;
    if (redirect_vld !== exp_rvld || redirect_pc !== exp_rpc)
      $display("FAIL redirect_nocommit: got vld=%b pc=%h, want %b %h", redirect_vld, redirect_pc, exp_rvld, exp_rpc);
    else passes++;
  endtask

  task automatic test_random();
    logic [AW-1:0] pool [5] = '{32'h1000, 32'h1404, 32'h14, 32'h320, 32'h0};
    logic [AW-1:0] cpc, lpc;
    for (int i = 0; i < 300; i++) begin
      pool[4] = $urandom;
      cpc = pool[$urandom_range(0, 4)];
      lpc = pool[$urandom_range(0, 4)];
      cycle(1'($urandom_range(0, 3) != 0), cpc, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)), $urandom,
            1'($urandom_range(0, 1)), lpc, 0);
      checks++;
      if (lookup_rsp_vld !== exp_rsp || (exp_rsp && lookup_taken !== exp_taken) ||
          redirect_vld !== exp_rvld || redirect_pc !== exp_rpc)
        $display("FAIL random_%0d: got rsp=%b tk=%b rv=%b rpc=%h, want rsp=%b tk=%b rv=%b rpc=%h",
                 i, lookup_rsp_vld, lookup_taken, redirect_vld, redirect_pc,
                 exp_rsp, exp_taken, exp_rvld, exp_rpc);
      else passes++;
    end
  endtask

  task automatic test_clear();
    int busy_cnt, done_cnt, n;
    for (int i = 0; i < 3; i++) cycle(1, 32'h14, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 32'h14, 1, 0, 0, 0, 1, 32'h14, 1);
    busy_cnt = clr_busy ? 1 : 0;
    done_cnt = 0;
    n = 0;
    while (clr_busy && n < 400) begin
      cycle(1, 32'h14, 1, 0, 0, 0, 1, 32'h14, (n < 10) ? 1'b1 : 1'b0);
      n++;
      if (clr_busy) busy_cnt++;
      if (clr_done) done_cnt++;
      checks++;
      if (clr_busy !== exp_busy || clr_done !== exp_done || lookup_taken !== exp_taken)
        $display("FAIL clear_cycle_%0d: got busy=%b done=%b tk=%b, want %b %b %b",
                 n, clr_busy, clr_done, lookup_taken, exp_busy, exp_done, exp_taken);
      else passes++;
    end
    checks++;
    if (busy_cnt != DEPTH || done_cnt != 1)
      $display("FAIL clear_length: got busy_cycles=%0d done_pulses=%0d, want %0d 1", busy_cnt, done_cnt, DEPTH);
    else passes++;
    cycle(1, 32'h14, 1, 0, 0, 0, 1, 32'h14, 0);
    checks++;
    if (lookup_taken !== 1'b0 || exp_taken !== 1'b0)
      $display("FAIL clear_entry_init: got taken=%b, want 0", lookup_taken);
    else passes++;
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h14, 0);
    checks++;
    if (lookup_taken !== exp_taken)
      $display("FAIL clear_entry_01: got taken=%b, want %b", lookup_taken, exp_taken);
    else passes++;
  endtask

  task automatic test_reset_mid_clear();
    int n;
    for (int i = 0; i < 3; i++) cycle(1, 32'h320, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 32'h1000, 0, 1, 0, 32'h5550, 0, 0, 1);
    n = 0;
    while (clr_left > DEPTH - 100 && n < 400) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      n++;
    end
    checks++;
    if (clr_busy !== 1'b1 || n != 100)
      $display("FAIL midclr_progress: got busy=%b cycles=%0d, want 1 100", clr_busy, n);
    else passes++;
    #2 rst_n = 0;
    drive_idle();
    model_reset();
    #1;
    checks++;
    if ({clr_busy, clr_done, redirect_vld, lookup_rsp_vld} !== 4'b0 || redirect_pc !== '0)
      $display("FAIL midclr_async: got busy=%b done=%b rv=%b rsp=%b rpc=%h, want 0",
               clr_busy, clr_done, redirect_vld, lookup_rsp_vld, redirect_pc);
    else passes++;
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h320, 0);
    checks++;
    if (lookup_taken !== 1'b0 || lookup_rsp_vld !== 1'b1)
      $display("FAIL midclr_init: got rsp=%b taken=%b, want 1 0", lookup_rsp_vld, lookup_taken);
    else passes++;
    cycle(1, 32'h320, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 1, 32'h320, 0);
    checks++;
    if (lookup_taken !== exp_taken || exp_taken !== 1'b1)
      $display("FAIL midclr_01: got taken=%b, want %b", lookup_taken, exp_taken);
    else passes++;
    for (int i = 0; i < 8; i++) begin
      cycle(0, 0, 0, 0, 0, 0, 1, $urandom, 0);
      checks++;
      if (lookup_taken !== exp_taken)
        $display("FAIL midclr_sweep_%0d: got taken=%b, want %b", i, lookup_taken, exp_taken);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_alias();
    test_redirect();
    test_random();
    test_clear();
    test_reset_mid_clear();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
